xsim_mem_arbiter: RTL and testbench

Shares the single simulation memory port between NUM_CLIENTS requesters. The shared port is the 64-bit read/write DPI memory model used under xsim. The block round-robin arbitrates per-client read/write requests and issues one operation at a time to the memory port. It captures read data one cycle after issue and returns a response (read data or write acknowledge) to the granted client with a valid/ready handshake. It sits between the DMA/portal clients of mkXsimTop and the memory read/write model.

---
 rtl/xsim_mem_arb_pkg.sv | 24 ++
 rtl/xsim_mem_arbiter_if.sv | 34 +++
 rtl/xsim_mem_arbiter_rr_arbiter.sv | 28 ++
 rtl/xsim_mem_arbiter.sv | 111 +++++++++++
 tb/tb_xsim_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xsim_mem_arb_pkg.sv
// Shared types for the xsim memory-port arbiter: FSM encoding, latched operation
// record and the client index width helper.
package xsim_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] handle;
        logic [31:0] addr;
        logic [63:0] wdata;
    } mem_op_t;

    // A single client still needs a one-bit index register.
    function automatic int client_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xsim_mem_arbiter_if.sv
// Client request/response and memory-model signals of the xsim memory arbiter.
// The arbiter uses the slave view; the clients plus memory model form the master side.
interface xsim_mem_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_W      = 64
);
    logic [NUM_CLIENTS-1:0]        req_valid;
    logic [NUM_CLIENTS-1:0]        req_ready;
    logic [NUM_CLIENTS-1:0]        req_write;
    logic [NUM_CLIENTS*32-1:0]     req_handle;
    logic [NUM_CLIENTS*32-1:0]     req_addr;
    logic [NUM_CLIENTS*DATA_W-1:0] req_wdata;
    logic [NUM_CLIENTS-1:0]        rsp_valid;
    logic [NUM_CLIENTS-1:0]        rsp_ready;
    logic [DATA_W-1:0]             rsp_data;
    logic                          mem_en_read64;
    logic                          mem_en_write64;
    logic [31:0]                   mem_handle;
    logic [31:0]                   mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic [DATA_W-1:0]             mem_rdata;

    modport slave (
        input  req_valid, req_write, req_handle, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data,
               mem_en_read64, mem_en_write64, mem_handle, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_handle, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data,
               mem_en_read64, mem_en_write64, mem_handle, mem_addr, mem_wdata
    );
endinterface

// File: rtl/xsim_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// modulo N. Usable on its own.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    always_comb begin
        int idx;
        idx          = 0;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/xsim_mem_arbiter.sv
// Round-robin arbiter sharing the single 64-bit xsim memory model port between
// NUM_CLIENTS requesters; one operation in flight, response returned by valid/ready.
module xsim_mem_arbiter
    import xsim_mem_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_W      = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    xsim_mem_arbiter_if.slave bus,
    output logic [31:0]       ops_done
);
    localparam int CLIENT_IDX_W = client_idx_w(NUM_CLIENTS);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ISSUE   = ISSUE;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    localparam logic [1:0] ST_RESP    = RESP;

    logic [1:0]              state;
    logic [CLIENT_IDX_W-1:0] rr_ptr;
    logic [CLIENT_IDX_W-1:0] cl_q;
    mem_op_t                 op_q;
    mem_op_t                 sel_op;
    logic [DATA_W-1:0]       rsp_data_q;
    logic [31:0]             ops_done_q;
    logic [NUM_CLIENTS-1:0]  grant_onehot;
    logic [NUM_CLIENTS-1:0]  cl_onehot;
    logic [CLIENT_IDX_W-1:0] grant_idx;
    logic                    grant_any;
    logic                    rsp_fire;
    logic                    issue;

    rr_arbiter #(.N(NUM_CLIENTS), .IW(CLIENT_IDX_W)) u_rr (
        .req          (bus.req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    always_comb begin
        sel_op = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_onehot[i]) begin
                sel_op.write  = bus.req_write[i];
                sel_op.handle = bus.req_handle[32*i +: 32];
                sel_op.addr   = bus.req_addr[32*i +: 32];
                sel_op.wdata  = bus.req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        cl_onehot = '0;
        for (int i = 0; i < NUM_CLIENTS; i++)
            cl_onehot[i] = (cl_q == CLIENT_IDX_W'(i));
    end

    // Other clients' rsp_ready never completes the response.
    assign rsp_fire = (state == ST_RESP) && |(bus.rsp_ready & cl_onehot);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cl_q       <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            ops_done_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (grant_any) begin
                    state  <= ST_ISSUE;
                    cl_q   <= grant_idx;
                    op_q   <= sel_op;
                    rr_ptr <= (grant_idx == CLIENT_IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
                end
                ST_ISSUE: if (op_q.write) begin
                    rsp_data_q <= '0;
                    state      <= ST_RESP;
                end else begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_data_q <= bus.mem_rdata;
                    state      <= ST_RESP;
                end
                ST_RESP: if (rsp_fire) begin
                    ops_done_q <= ops_done_q + 32'd1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Reset masks every outward strobe/valid in the cycle it is asserted.
    assign issue              = (state == ST_ISSUE) && RST_N;
    assign bus.mem_en_write64 = issue && op_q.write;
    assign bus.mem_en_read64  = issue && !op_q.write;
    assign bus.mem_handle     = issue ? op_q.handle : '0;
    assign bus.mem_addr       = issue ? op_q.addr : '0;
    assign bus.mem_wdata      = issue ? op_q.wdata : '0;
    assign bus.req_ready      = (state == ST_IDLE && RST_N) ? grant_onehot : '0;
    assign bus.rsp_valid      = (state == ST_RESP && RST_N) ? cl_onehot : '0;
    assign bus.rsp_data       = rsp_data_q;
    assign ops_done           = ops_done_q;

endmodule

// File: tb/tb_xsim_mem_arbiter.sv
// Randomized + directed bench for xsim_mem_arbiter against a transaction-level
// reference (round-robin rule, fixed latencies, sparse memory map).
module tb_xsim_mem_arbiter;
    localparam int NC = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] ops_done;

    xsim_mem_arbiter_if #(.NUM_CLIENTS(NC), .DATA_W(64)) bus ();

    xsim_mem_arbiter #(.NUM_CLIENTS(NC), .DATA_W(64)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .bus      (bus),
        .ops_done (ops_done)
    );

    always #5 CLK = ~CLK;

    // Memory model environment: read data appears the cycle after the strobe, noise otherwise.
    logic [63:0]  env_mem [128];
    logic [127:0] env_wr = '0;

    function automatic logic [6:0] env_key(input logic [31:0] h, input logic [31:0] a);
        return {h[1:0], a[7:3]};
    endfunction

    always @(posedge CLK) begin
        if (bus.mem_en_write64) begin
            env_mem[env_key(bus.mem_handle, bus.mem_addr)] <= bus.mem_wdata;
            env_wr[env_key(bus.mem_handle, bus.mem_addr)]  <= 1'b1;
        end
        if (bus.mem_en_read64)
            bus.mem_rdata <= env_wr[env_key(bus.mem_handle, bus.mem_addr)] ?
                             env_mem[env_key(bus.mem_handle, bus.mem_addr)] :
                             {32'hDEADBEEF, bus.mem_addr};
        else
            bus.mem_rdata <= {$urandom, $urandom};
    end

    // Reference model state
    logic [63:0] ref_mem [logic [63:0]];
    int          m_ptr = 0;
    bit          m_busy = 0;
    int          m_age = 0;
    int          m_cl = 0;
    bit          m_wr = 0;
    logic [31:0] m_h, m_a;
    logic [63:0] m_wd, m_rd;
    logic [31:0] m_cnt = 0;

    bit keep_req = 0;
    bit rand_mode = 0;
    int last_grant;
    int grant_log [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int c, input bit w, input logic [31:0] h,
                           input logic [31:0] a, input logic [63:0] d);
        bus.req_valid[c]          = 1'b1;
        bus.req_write[c]          = w;
        bus.req_handle[32*c +: 32] = h;
        bus.req_addr[32*c +: 32]   = a;
        bus.req_wdata[64*c +: 64]  = d;
    endtask

    task automatic rand_fields(input int c);
        bus.req_write[c]          = 1'($urandom_range(1));
        bus.req_handle[32*c +: 32] = 32'($urandom_range(3));
        bus.req_addr[32*c +: 32]   = 32'($urandom_range(31)) << 3;
        bus.req_wdata[64*c +: 64]  = {$urandom, $urandom};
    endtask

    // One cycle: entered at a negedge with inputs settled, returns at the next negedge.
    task automatic step();
        logic [NC-1:0] e_rdy, e_rv, vin, rin;
        logic          e_r, e_w;
        logic [31:0]   e_h, e_a, g_h, g_a;
        logic [63:0]   e_wd, g_wd;
        bit            g_w;
        int            win, c;
        #1;
        vin = bus.req_valid;
        rin = bus.rsp_ready;
        win = -1;
        e_rdy = '0;
        if (RST_N && !m_busy)
            for (int k = 0; k < NC; k++) begin
                c = (m_ptr + k) % NC;
                if (win < 0 && vin[c]) win = c;
            end
        g_w = 0; g_h = '0; g_a = '0; g_wd = '0;
        if (win >= 0) begin
            e_rdy[win] = 1'b1;
            g_w  = bus.req_write[win];
            g_h  = bus.req_handle[32*win +: 32];
            g_a  = bus.req_addr[32*win +: 32];
            g_wd = bus.req_wdata[64*win +: 64];
        end
        e_r = 0; e_w = 0; e_h = '0; e_a = '0; e_wd = '0;
        if (RST_N && m_busy && m_age == 1) begin
            e_r = !m_wr; e_w = m_wr; e_h = m_h; e_a = m_a; e_wd = m_wd;
        end
        e_rv = '0;
        if (RST_N && m_busy && m_age >= (m_wr ? 2 : 3)) e_rv[m_cl] = 1'b1;

        last_grant = -1;
        for (int i = 0; i < NC; i++)
            if (bus.req_ready[i] && vin[i]) last_grant = i;
        if (last_grant >= 0) grant_log.push_back(last_grant);

        check("req_ready", bus.req_ready, e_rdy);
        check("mem_strobe", {bus.mem_en_read64, bus.mem_en_write64, bus.mem_handle, bus.mem_addr},
              {e_r, e_w, e_h, e_a});
        check("mem_wdata", bus.mem_wdata, e_wd);
        check("rsp_valid", bus.rsp_valid, e_rv);
        if (e_rv != '0) check("rsp_data", bus.rsp_data, m_wr ? 64'h0 : m_rd);
        check("ops_done", ops_done, m_cnt);

        @(posedge CLK);
        if (!RST_N) begin
            m_busy = 0; m_ptr = 0; m_cnt = '0;
        end else if (m_busy) begin
            if (e_rv[m_cl] && rin[m_cl]) begin
                m_busy = 0;
                m_cnt  = m_cnt + 32'd1;
            end else begin
                m_age++;
            end
        end else if (win >= 0) begin
            m_busy = 1; m_age = 1; m_cl = win; m_ptr = (win + 1) % NC;
            m_wr = g_w; m_h = g_h; m_a = g_a; m_wd = g_wd;
            if (m_wr) ref_mem[{m_h, m_a}] = m_wd;
            else m_rd = ref_mem.exists({m_h, m_a}) ? ref_mem[{m_h, m_a}] : {32'hDEADBEEF, m_a};
        end

        @(negedge CLK);
        if (win >= 0) begin
            if (keep_req) rand_fields(win);
            else bus.req_valid[win] = 1'b0;
        end
        if (rand_mode) begin
            for (int i = 0; i < NC; i++) begin
                if (!bus.req_valid[i] && $urandom_range(99) < 40) begin
                    rand_fields(i);
                    bus.req_valid[i] = 1'b1;
                end
                bus.rsp_ready[i] = ($urandom_range(99) < 70);
            end
        end
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_handle = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = '1;
        @(posedge CLK);
        @(negedge CLK);
        repeat (2) step();
        RST_N = 1'b1;
        step();

        // Single read, client 1
        set_req(1, 1'b0, 32'd3, 32'h40, 64'h0);
        repeat (6) step();
        check("single_rd_cnt", ops_done, 32'd1);

        // Write then readback, client 0
        set_req(0, 1'b1, 32'd0, 32'h80, 64'h1122334455667788);
        repeat (5) step();
        set_req(0, 1'b0, 32'd0, 32'h80, 64'h0);
        repeat (6) step();
        check("wr_rd_cnt", ops_done, 32'd3);

        // Contention from a fresh reset
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        grant_log.delete();
        keep_req = 1;
        for (int i = 0; i < NC; i++) begin
            rand_fields(i);
            bus.req_valid[i] = 1'b1;
        end
        repeat (22) step();
        keep_req = 0;
        bus.req_valid = '0;
        repeat (6) step();
        check("grant_count", grant_log.size() >= 5, 1'b1);
        for (int i = 0; i < 5; i++)
            check($sformatf("grant_order%0d", i), grant_log[i], i % NC);

        // Response backpressure with a competing requester
        bus.rsp_ready = '0;
        set_req(2, 1'b0, 32'd2, 32'h18, 64'h0);
        step();
        set_req(3, 1'b1, 32'd1, 32'h20, 64'hA5A5);
        repeat (7) step();
        check("bp_held_valid", bus.rsp_valid, 4'b0100);
        bus.rsp_ready = 4'b1011;
        step();
        check("bp_ignored", bus.rsp_valid, 4'b0100);
        bus.rsp_ready = '1;
        step();
        repeat (6) step();

        // Reset during CAPTURE
        set_req(1, 1'b0, 32'd1, 32'h10, 64'h0);
        repeat (2) step();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        repeat (3) step();
        check("rst_cnt", ops_done, 32'd0);
        set_req(0, 1'b0, 32'd0, 32'h8, 64'h0);
        set_req(3, 1'b0, 32'd3, 32'h8, 64'h0);
        step();
        check("ptr_after_rst", last_grant, 0);
        repeat (12) step();

        // ops_done wrap
        force dut.ops_done_q = 32'hFFFF_FFFF;
        #1;
        release dut.ops_done_q;
        m_cnt = 32'hFFFF_FFFF;
        set_req(2, 1'b1, 32'd0, 32'h30, 64'h55);
        repeat (5) step();
        check("wrap", ops_done, 32'd0);

        // Randomized traffic with random backpressure
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
